mul_sqrt_seq: RTL and testbench

Parametrised, self-contained sequential arithmetic unit that is the next generation of the a*sqrt(b) datapath. It computes one of four unsigned functions of two WIDTH-bit operands: a*isqrt(b), a*b, isqrt(b), or isqrt(a*b). It uses an internal shift-add multiplier and a restoring digit-by-digit square root, sequenced by a single FSM with a start/busy/done handshake. Mode-dependent latency is fixed and exact.

---
 rtl/mul_sqrt_seq_if.sv | 22 ++
 rtl/mul_sqrt_seq.sv | 140 ++++++++++++++
 tb/tb_mul_sqrt_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mul_sqrt_seq_if.sv
// Handshake and operand bus for the sequential multiply / square-root unit.
interface mul_sqrt_seq_if #(
   parameter int WIDTH = 8
);
   logic                   start_i;
   logic [1:0]             mode_i;
   logic [WIDTH-1:0]       a_bi;
   logic [WIDTH-1:0]       b_bi;
   logic                   busy_o;
   logic                   done_o;
   logic [2*WIDTH-1:0]     y_bo;

   modport slave (
      input  start_i, mode_i, a_bi, b_bi,
      output busy_o, done_o, y_bo
   );

   modport master (
      output start_i, mode_i, a_bi, b_bi,
      input  busy_o, done_o, y_bo
   );
endinterface

// File: rtl/mul_sqrt_seq.sv
// Sequential unit computing a*isqrt(b), a*b, isqrt(b) or isqrt(a*b).
// Shift-add multiplier (one bit per cycle) and restoring square root
// (one root bit per cycle) share a single sequencing FSM.
//
// state  | meaning
// IDLE   | waiting for start; busy low
// MUL    | one multiplier bit per cycle
// SQRT   | one root bit per cycle, two radicand bits consumed
// DONE   | final cycle; result registered to y on the next edge
//
// DONE is the last busy cycle: the edge that leaves it raises done_o and
// drops busy_o, so a start presented in the done_o cycle is accepted.
module mul_sqrt_seq #(
   parameter int WIDTH = 8
) (
   input  logic           clk_i,
   input  logic           rst_i,
   mul_sqrt_seq_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam int RW = WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_SQRT, S_DONE} state_t;

   state_t               r_state;
   logic [1:0]           r_mode;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_rad;
   logic [RW-1:0]        r_rem;
   logic [WIDTH-1:0]     r_root;
   logic                 r_busy;
   logic                 r_done;
   logic [2*WIDTH-1:0]   r_y;

   logic [2*WIDTH-1:0]   w_acc_next;
   logic [RW+1:0]        w_rem_sh;
   logic [RW+1:0]        w_trial;
   logic                 w_ge;
   logic [WIDTH-1:0]     w_root_next;

   // Datapath step values for the current MUL / SQRT iteration.
   assign w_acc_next  = r_mplier[0] ? r_acc + r_mcand : r_acc;
   assign w_rem_sh    = {r_rem, r_rad[2*WIDTH-1 -: 2]};
   assign w_trial     = {1'b0, r_root, 2'b01};
   assign w_ge        = (w_rem_sh >= w_trial);
   assign w_root_next = {r_root[WIDTH-2:0], w_ge};

   // Sequencing FSM and datapath registers, synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state  <= S_IDLE;
         r_mode   <= '0;
         r_cnt    <= '0;
         r_a      <= '0;
         r_mplier <= '0;
         r_mcand  <= '0;
         r_acc    <= '0;
         r_rad    <= '0;
         r_rem    <= '0;
         r_root   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_y      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start_i) begin
                  r_busy <= 1'b1;
                  r_a    <= bus.a_bi;
                  r_mode <= bus.mode_i;
                  if (bus.mode_i[0]) begin
                     r_state  <= S_MUL;
                     r_mplier <= bus.b_bi;
                     r_mcand  <= {{WIDTH{1'b0}}, bus.a_bi};
                     r_acc    <= '0;
                     r_cnt    <= CW'(WIDTH - 1);
                  end else begin
                     r_state <= S_SQRT;
                     r_rad   <= {bus.b_bi, {WIDTH{1'b0}}};
                     r_rem   <= '0;
                     r_root  <= '0;
                     r_cnt   <= CW'(WIDTH/2 - 1);
                  end
               end
            end
            S_MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt - CW'(1);
               if (r_cnt == '0) begin
                  if (r_mode == 2'b11) begin
                     // root of the full 2*WIDTH-bit product
                     r_state <= S_SQRT;
                     r_rad   <= w_acc_next;
                     r_rem   <= '0;
                     r_root  <= '0;
                     r_cnt   <= CW'(WIDTH - 1);
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_SQRT: begin
               r_rad  <= r_rad << 2;
               r_rem  <= w_ge ? RW'(w_rem_sh - w_trial) : RW'(w_rem_sh);
               r_root <= w_root_next;
               r_cnt  <= r_cnt - CW'(1);
               if (r_cnt == '0) begin
                  if (r_mode == 2'b00) begin
                     r_state  <= S_MUL;
                     r_mplier <= w_root_next;
                     r_mcand  <= {{WIDTH{1'b0}}, r_a};
                     r_acc    <= '0;
                     r_cnt    <= CW'(WIDTH - 1);
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_y     <= r_mode[1] ? {{WIDTH{1'b0}}, r_root} : r_acc;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy_o = r_busy;
   assign bus.done_o = r_done;
   assign bus.y_bo   = r_y;
endmodule

// File: tb/tb_mul_sqrt_seq.sv
// Directed bench for mul_sqrt_seq (WIDTH=8): results, latencies, handshake, reset abort.
module tb_mul_sqrt_seq;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   errors = 0;
   int   checks = 0;

   mul_sqrt_seq_if #(.WIDTH(8)) u_if ();

   mul_sqrt_seq #(.WIDTH(8)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (u_if.slave)
   );

   always #5 clk_i = ~clk_i;

   // Launch one operation from a post-edge point where busy_o=0 and wait for done_o.
   // Operand inputs are scrambled after accept to prove they were latched.
   task automatic run_op(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] y, output int lat, output int nbusy,
                         output logic busy0);
      u_if.start_i = 1'b1;
      u_if.mode_i  = m;
      u_if.a_bi    = a;
      u_if.b_bi    = b;
      @(posedge clk_i);
      #1;
      u_if.start_i = 1'b0;
      u_if.a_bi    = ~a;
      u_if.b_bi    = ~b;
      u_if.mode_i  = ~m;
      busy0 = u_if.busy_o;
      lat   = -1;
      nbusy = 0;
      y     = '0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk_i);
         #1;
         if (u_if.done_o) begin
            lat = n;
            y   = u_if.y_bo;
            break;
         end
         if (u_if.busy_o) nbusy++;
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      checks++; if (u_if.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", u_if.busy_o); end
      checks++; if (u_if.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", u_if.done_o); end
      checks++; if (u_if.y_bo !== 16'd0) begin errors++; $display("FAIL reset_y got=%0d exp=0", u_if.y_bo); end
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_mode00();
      logic [15:0] y; int lat; int nb; logic b0;
      run_op(2'b00, 8'd10, 8'd49, y, lat, nb, b0);
      checks++; if (y !== 16'd70) begin errors++; $display("FAIL m00_10_49_y got=%0d exp=70", y); end
      checks++; if (lat != 13) begin errors++; $display("FAIL m00_latency got=%0d exp=13", lat); end
      checks++; if (nb != 12) begin errors++; $display("FAIL m00_busy_cycles got=%0d exp=12", nb); end
      checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL m00_busy_after_accept got=%0b exp=1", b0); end
      run_op(2'b00, 8'd255, 8'd255, y, lat, nb, b0);
      checks++; if (y !== 16'd3825) begin errors++; $display("FAIL m00_255_255_y got=%0d exp=3825", y); end
      checks++; if (lat != 13) begin errors++; $display("FAIL m00_latency2 got=%0d exp=13", lat); end
   endtask

   task automatic test_mode01();
      logic [15:0] y; int lat; int nb; logic b0;
      run_op(2'b01, 8'd255, 8'd255, y, lat, nb, b0);
      checks++; if (y !== 16'd65025) begin errors++; $display("FAIL m01_255_255_y got=%0d exp=65025", y); end
      checks++; if (lat != 9) begin errors++; $display("FAIL m01_latency got=%0d exp=9", lat); end
      checks++; if (nb != 8) begin errors++; $display("FAIL m01_busy_cycles got=%0d exp=8", nb); end
      run_op(2'b01, 8'd0, 8'd200, y, lat, nb, b0);
      checks++; if (y !== 16'd0) begin errors++; $display("FAIL m01_a0_y got=%0d exp=0", y); end
      run_op(2'b01, 8'd13, 8'd17, y, lat, nb, b0);
      checks++; if (y !== 16'd221) begin errors++; $display("FAIL m01_13_17_y got=%0d exp=221", y); end
   endtask

   task automatic test_mode10();
      logic [15:0] y; int lat; int nb; logic b0;
      logic [7:0]  bv [3] = '{8'd255, 8'd0, 8'd64};
      logic [15:0] ev [3] = '{16'd15, 16'd0, 16'd8};
      for (int i = 0; i < 3; i++) begin
         run_op(2'b10, 8'd99, bv[i], y, lat, nb, b0);
         checks++; if (y !== ev[i]) begin errors++; $display("FAIL m10_y b=%0d got=%0d exp=%0d", bv[i], y, ev[i]); end
         checks++; if (lat != 5) begin errors++; $display("FAIL m10_latency b=%0d got=%0d exp=5", bv[i], lat); end
      end
   endtask

   task automatic test_mode11();
      logic [15:0] y; int lat; int nb; logic b0;
      logic [7:0]  av [3] = '{8'd200, 8'd255, 8'd3};
      logic [7:0]  bv [3] = '{8'd50, 8'd255, 8'd3};
      logic [15:0] ev [3] = '{16'd100, 16'd255, 16'd3};
      for (int i = 0; i < 3; i++) begin
         run_op(2'b11, av[i], bv[i], y, lat, nb, b0);
         checks++; if (y !== ev[i]) begin errors++; $display("FAIL m11_y a=%0d b=%0d got=%0d exp=%0d", av[i], bv[i], y, ev[i]); end
         checks++; if (lat != 17) begin errors++; $display("FAIL m11_latency a=%0d got=%0d exp=17", av[i], lat); end
      end
   endtask

   task automatic test_handshake();
      int ndone = 0;
      int lat   = -1;
      logic [15:0] y = '0;
      u_if.start_i = 1'b1;
      u_if.mode_i  = 2'b01;
      u_if.a_bi    = 8'd12;
      u_if.b_bi    = 8'd11;
      @(posedge clk_i);
      for (int n = 1; n <= 40; n++) begin
         #1;
         if (u_if.done_o) begin
            ndone++;
            lat = n - 1;
            y   = u_if.y_bo;
            u_if.start_i = 1'b0;
            break;
         end
         u_if.a_bi   = 8'(n * 37);
         u_if.b_bi   = 8'(n * 11 + 3);
         u_if.mode_i = 2'(n);
         @(posedge clk_i);
      end
      for (int n = 0; n < 20; n++) begin
         @(posedge clk_i);
         #1;
         if (u_if.done_o) ndone++;
      end
      checks++; if (y !== 16'd132) begin errors++; $display("FAIL hs_latched_y got=%0d exp=132", y); end
      checks++; if (lat != 9) begin errors++; $display("FAIL hs_latency got=%0d exp=9", lat); end
      checks++; if (ndone != 1) begin errors++; $display("FAIL hs_done_count got=%0d exp=1", ndone); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] y; int lat; int nb; logic b0;
      run_op(2'b01, 8'd7, 8'd9, y, lat, nb, b0);
      checks++; if (y !== 16'd63) begin errors++; $display("FAIL b2b_first_y got=%0d exp=63", y); end
      // start now lands in the done_o cycle
      run_op(2'b10, 8'd0, 8'd64, y, lat, nb, b0);
      checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL b2b_busy_next got=%0b exp=1", b0); end
      checks++; if (y !== 16'd8) begin errors++; $display("FAIL b2b_second_y got=%0d exp=8", y); end
      checks++; if (lat != 5) begin errors++; $display("FAIL b2b_latency got=%0d exp=5", lat); end
   endtask

   task automatic test_reset_midop();
      logic [15:0] y; int lat; int nb; logic b0;
      int ndone = 0;
      u_if.start_i = 1'b1;
      u_if.mode_i  = 2'b00;
      u_if.a_bi    = 8'd10;
      u_if.b_bi    = 8'd49;
      @(posedge clk_i);
      #1;
      u_if.start_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      checks++; if (u_if.busy_o !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%0b exp=0", u_if.busy_o); end
      checks++; if (u_if.done_o !== 1'b0) begin errors++; $display("FAIL rmid_done got=%0b exp=0", u_if.done_o); end
      checks++; if (u_if.y_bo !== 16'd0) begin errors++; $display("FAIL rmid_y got=%0d exp=0", u_if.y_bo); end
      for (int n = 0; n < 20; n++) begin
         @(posedge clk_i);
         #1;
         if (u_if.done_o) ndone++;
      end
      checks++; if (ndone != 0) begin errors++; $display("FAIL rmid_no_done got=%0d exp=0", ndone); end
      run_op(2'b00, 8'd10, 8'd49, y, lat, nb, b0);
      checks++; if (y !== 16'd70) begin errors++; $display("FAIL rmid_restart_y got=%0d exp=70", y); end
      checks++; if (lat != 13) begin errors++; $display("FAIL rmid_restart_latency got=%0d exp=13", lat); end
   endtask

   initial begin
      u_if.start_i = 1'b0;
      u_if.mode_i  = 2'b00;
      u_if.a_bi    = '0;
      u_if.b_bi    = '0;
      test_reset();
      test_mode00();
      test_mode01();
      test_mode10();
      test_mode11();
      test_handshake();
      test_back_to_back();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
